// File: rtl/stream_out_sched.sv
// Round-robin scheduler that arbitrates N_REQ PEA output streams onto one DMA
// channel in bursts, with a zero-latency combinational data path.
module stream_out_sched #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [7:0]              burst_len_i,
    input  logic [CNT_W-1:0]        total_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    dma_valid_o,
    output logic [DATA_W-1:0]       dma_data_o,
    input  logic                    dma_ready_i,
    output logic [SEL_W-1:0]        grant_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_W-1:0]        beats_o
);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_DONE} state_e;

    state_e           state_q;
    logic [SEL_W-1:0] rr_ptr_q;
    logic [SEL_W-1:0] grant_q;
    logic [CNT_W-1:0] beats_q;
    logic [7:0]       burst_cnt_q;
    logic [7:0]       burst_len_q;
    logic [CNT_W-1:0] total_q;

    logic [SEL_W-1:0] arb_sel_d;
    logic [SEL_W-1:0] rr_ptr_d;
    logic             beat_d;
    logic             last_beat_d;
    logic             burst_end_d;

    // Winner is the valid requester with the smallest distance above rr_ptr_q.
    always_comb begin
        int off;
        int best_off;
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        arb_sel_d = grant_q;
        best_off  = N_REQ;
        off       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            off = (k - int'(rr_ptr_q) + N_REQ) % N_REQ;
            if (req_valid_i[k] && (off < best_off)) begin
                best_off  = off;
                arb_sel_d = SEL_W'(k);
            end
        end
    end

    always_comb begin
        dma_valid_o = 1'b0;
        dma_data_o  = '0;
        req_ready_o = '0;
        if (state_q == S_XFER) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_q == SEL_W'(k)) begin
                    dma_valid_o    = req_valid_i[k];
                    dma_data_o     = req_data_i[k*DATA_W +: DATA_W];
                    req_ready_o[k] = dma_ready_i;
                end
            end
        end
    end

    assign beat_d      = (state_q == S_XFER) && dma_valid_o && dma_ready_i;
    assign last_beat_d = (beats_q + CNT_W'(1)) == total_q;
    assign burst_end_d = (burst_len_q != 8'd0) && ((burst_cnt_q + 8'd1) == burst_len_q);
    assign rr_ptr_d    = SEL_W'((int'(grant_q) + 1) % N_REQ);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beats_q     <= '0;
            burst_cnt_q <= '0;
            burst_len_q <= '0;
            total_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        beats_q <= '0;
                        if (total_i != '0) begin
                            burst_len_q <= burst_len_i;
                            total_q     <= total_i;
                            burst_cnt_q <= '0;
                            state_q     <= S_ARB;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_ARB: begin
                    if (|req_valid_i) begin
                        grant_q     <= arb_sel_d;
                        burst_cnt_q <= '0;
                        state_q     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (beat_d) begin
                        beats_q     <= beats_q + CNT_W'(1);
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                        // Job end wins over burst end, so the final beat never re-arbitrates.
                        if (last_beat_d) begin
                            state_q <= S_DONE;
                        end else if (burst_end_d) begin
                            rr_ptr_q <= rr_ptr_d;
                            state_q  <= S_ARB;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign beats_o = beats_q;
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);

endmodule

// File: doc/stream_out_sched.md
STREAM_OUT_SCHED -- requirements
Module: stream_out_sched

Interface
REQ-001: Parameter N_REQ, default 2 (N_PEA_DOUT_PER_OUT_STREAM), SHALL be the number of PEA outputs arbitrated onto one DMA channel.
REQ-002: Parameter DATA_W, default 32, SHALL be the beat data width.
REQ-003: Parameter CNT_W, default 16, SHALL be the total-beat counter width.
REQ-004: Parameter SEL_W, default 1 (LOG_N_PEA_DOUT_PER_OUT_STREAM), SHALL be the grant index width.
REQ-005: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006: rst_i  in  1  reset, synchronous, active-high.
REQ-007: start_i  in  1  one-cycle pulse that launches a transfer job.
REQ-008: burst_len_i  in  8  beats per grant; 0 = unlimited (grant held until job end).
REQ-009: total_i  in  CNT_W  total beats in the job.
REQ-010: req_valid_i  in  N_REQ  per-PEA-output valid.
REQ-011: req_data_i  in  N_REQ*DATA_W  per-PEA-output data, requester k in bits [k*DATA_W +: DATA_W].
REQ-012: req_ready_o  out  N_REQ  per-PEA-output ready.
REQ-013: dma_valid_o  out  1  DMA-channel valid.
REQ-014: dma_data_o  out  DATA_W  DMA-channel data.
REQ-015: dma_ready_i  in  1  DMA-channel ready.
REQ-016: grant_o  out  SEL_W  index of the current grant holder.
REQ-017: busy_o  out  1  high in every state except IDLE.
REQ-018: done_o  out  1  one-cycle job-completion pulse.
REQ-019: beats_o  out  CNT_W  beats transferred in the current or last job.

Function
REQ-020: The block SHALL implement the FSM states IDLE, ARB, XFER and DONE.
REQ-021: In IDLE, start_i with total_i!=0 SHALL latch burst_len_i and total_i, clear beats_o and the burst counter, and move to ARB.
REQ-022: In IDLE, start_i with total_i==0 SHALL clear beats_o and move directly to DONE.
REQ-023: start_i SHALL be ignored in ARB, XFER and DONE.
REQ-024: In ARB, the block SHALL scan req_valid_i from rr_ptr upward with wrap modulo N_REQ, register the first valid index into grant_o, clear the burst counter and move to XFER on the next cycle.
REQ-025: In ARB with no req_valid_i set, the block SHALL stay in ARB and leave grant_o unchanged.
REQ-026: In XFER, combinationally: dma_valid_o = req_valid_i[grant_o]; dma_data_o = req_data_i[grant_o]; req_ready_o[grant_o] = dma_ready_i.
REQ-027: All non-granted req_ready_o bits SHALL be 0 at all times.
REQ-028: Outside XFER, dma_valid_o and all req_ready_o bits SHALL be 0; dma_data_o is don't-care.
REQ-029: A beat SHALL count only on dma_valid_o & dma_ready_i in XFER; each beat increments beats_o and the burst counter by 1.
REQ-030: On a beat where beats_o+1 == latched total, the block SHALL go to DONE; this takes priority over burst end.
REQ-031: Otherwise, on a beat where burst_len!=0 and burst counter+1 == burst_len, the block SHALL set rr_ptr = (grant_o+1) mod N_REQ and go to ARB.
REQ-032: The cost of re-arbitration SHALL be exactly one ARB cycle with no transfer (a bubble).
REQ-033: The granted requester SHALL NOT change during XFER, even if it deasserts valid; the block waits.
REQ-034: In DONE, done_o SHALL be 1 for that single cycle, then the block returns to IDLE.
REQ-035: beats_o SHALL hold its final value until the next accepted start_i.
REQ-036: The data path SHALL have zero latency (combinational pass-through), with no internal data buffering.

Reset
REQ-037: rst_i high at a clock edge SHALL force state=IDLE, rr_ptr=0, grant_o=0, beats_o=0, burst counter=0 and latched config=0.
REQ-038: The forced values SHALL make busy_o=0, done_o=0, dma_valid_o=0 and req_ready_o=0 in the cycle after that edge.
REQ-039: Reset asserted mid-job SHALL abort the job with no done_o pulse; beats in flight are lost.
REQ-040: Reset SHALL take priority over start_i in the same cycle.

Verification
REQ-041: Basic job: N_REQ=2, total=6, burst=2, both requesters valid, dma_ready=1 -> grant sequence 0,0,1,1,0,0 with one bubble cycle between bursts, beats_o=6, done_o pulses once, busy_o low afterwards.
REQ-042: Backpressure and idle: total=4, burst=0, only req1 valid, dma_ready toggled 1,0,1,0 -> grant_o=1 throughout, beats counted only on ready cycles, req_ready_o[0]=0 always, done_o after the 4th beat.
REQ-043: Valid drop: the granted requester drops valid for 3 cycles mid-burst while the other is valid -> no grant change, no beats counted, and the job resumes when valid returns.
REQ-044: Boundaries: start with total=0 -> done_o the next cycle with beats_o=0; total=3, burst=2 -> the third beat ends the job in DONE, not ARB; start_i pulsed during XFER -> ignored.
REQ-045: Reset mid-job: rst_i asserted after 2 of 8 beats -> all outputs at reset values the next cycle, no done_o; a new start afterwards begins with grant 0 (rr_ptr=0).
